// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: two requester channels and the single response channel of the ALU arbiter
interface alu_arbiter_if #(
    parameter int WIDTH = 16
);
    logic             req_valid_0, req_valid_1;
    logic             req_ready_0, req_ready_1;
    logic [WIDTH-1:0] op1_0, op2_0, op1_1, op2_1;
    logic [1:0]       mode_0, mode_1;
    logic             rsp_valid, rsp_id, rsp_zero, rsp_carry, rsp_ready;
    logic [WIDTH-1:0] rsp_data;

    modport master (
        output req_valid_0, req_valid_1, op1_0, op2_0, op1_1, op2_1, mode_0, mode_1, rsp_ready,
        input  req_ready_0, req_ready_1, rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_carry
    );

    modport slave (
        input  req_valid_0, req_valid_1, op1_0, op2_0, op1_1, op2_1, mode_0, mode_1, rsp_ready,
        output req_ready_0, req_ready_1, rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_carry
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter for two requesters feeding a single-entry registered ALU result
module alu_arbiter #(
    parameter int WIDTH = 16
) (
    input logic          clk,
    input logic          rst_n,
    alu_arbiter_if.slave bus
);
    typedef enum logic {IDLE, FULL} state_t;

    state_t           state;
    logic             last_grant, win, can_accept, grant, carry;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a, b, res;
    logic [WIDTH:0]   sum;

    always_comb begin
        win        = (bus.req_valid_0 && bus.req_valid_1) ? ~last_grant : bus.req_valid_1;
        can_accept = rst_n && (state == IDLE || bus.rsp_ready);
        grant      = can_accept && (win ? bus.req_valid_1 : bus.req_valid_0);
        a          = win ? bus.op1_1 : bus.op1_0;
        b          = win ? bus.op2_1 : bus.op2_0;
        mode       = win ? bus.mode_1 : bus.mode_0;
        sum        = {1'b0, a} + {1'b0, b};
        res        = mode == 2'd0 ? sum[WIDTH-1:0] : mode == 2'd1 ? ~a : mode == 2'd2 ? a : '0;
        carry      = mode == 2'd0 && sum[WIDTH];
    end

    assign bus.req_ready_0 = can_accept && !win;
    assign bus.req_ready_1 = can_accept && win;
    assign bus.rsp_valid   = state == FULL;

    // A grant while FULL overwrites the held result, so accept and refill share one edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            bus.rsp_id    <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_zero  <= 1'b0;
            bus.rsp_carry <= 1'b0;
        end else if (grant) begin
            state         <= FULL;
            last_grant    <= win;
            bus.rsp_id    <= win;
            bus.rsp_data  <= res;
            bus.rsp_zero  <= res == '0;
            bus.rsp_carry <= carry;
        end else if (bus.rsp_ready) begin
            state <= IDLE;
        end
    end
endmodule
